// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I sequencing FSM with memory-ready stalls and bus timeout
// Optional cycle/instret counters are compiled in when MCYCLE_CNT_EN is defined.
module multicycle_ctrl #(
    parameter int WAIT_MAX = 0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             Zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             MemReady,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ImmSrc,
    output logic             IllegalInstr,
    output logic             BusErr,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstRet
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // The counter only has to reach WAIT_MAX-1: that is the last waiting cycle.
    localparam int WAIT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam int WAIT_LAST = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK
    } state_t;

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expired;
    logic              illegal;
    logic              bus_err;

    assign wait_expired = (WAIT_MAX > 0) && !MemReady && (wait_cnt == WAIT_W'(WAIT_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state || bus_err)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCUpdate   = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        ResultSrc  = 2'b00;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (wait_expired) begin
                    bus_err    = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    IRWrite  = MemReady;
                    PCUpdate = MemReady;
                    if (MemReady) next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXECR;
                    OP_I:              next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_ALUWB;
                    default: begin
                        illegal    = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (wait_expired) begin
                    bus_err    = 1'b1;
                    next_state = S_FETCH;
                end else if (MemReady) begin
                    next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                if (wait_expired) begin
                    bus_err    = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    MemWrite = 1'b1;
                    if (MemReady) next_state = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b10;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUOp      = 2'b10;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                next_state = S_FETCH;
                case (funct3)
                    3'b000:  PCUpdate = Zero;
                    3'b001:  PCUpdate = !Zero;
                    3'b100:  PCUpdate = lt;
                    3'b101:  PCUpdate = !lt;
                    3'b110:  PCUpdate = ltu;
                    3'b111:  PCUpdate = !ltu;
                    default: illegal  = 1'b1;
                endcase
            end
            S_JAL: begin
                PCUpdate   = 1'b1;
                next_state = S_LINK;
            end
            S_JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                PCUpdate   = 1'b1;
                next_state = S_LINK;
            end
            S_LINK: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
        // Reset overrides every side-effecting strobe, aborting any access in flight.
        if (reset) begin
            IRWrite  = 1'b0;
            PCUpdate = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            illegal  = 1'b0;
            bus_err  = 1'b0;
        end
    end

    assign IllegalInstr = illegal;
    assign BusErr       = bus_err;

    always_comb begin
        case (op)
            OP_STORE:         ImmSrc = 3'b001;
            OP_BRANCH:        ImmSrc = 3'b010;
            OP_JAL:           ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

`ifdef MCYCLE_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    // A bus-error abort out of MEMWRITE does not count as a retirement.
    assign retire = (next_state == S_FETCH) &&
                    ((state == S_MEMWB) || (state == S_ALUWB) || (state == S_LINK) ||
                     (state == S_BRANCH && !illegal) || (state == S_MEMWRITE && !bus_err));

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    assign CycleCnt = cycle_q;
    assign InstRet  = instret_q;
`else
    assign CycleCnt = '0;
    assign InstRet  = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl (WAIT_MAX=4)
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       op = '0;
    logic [2:0]       funct3 = '0;
    logic             Zero = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic             MemReady = 1'b1;
    logic             AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, IllegalInstr, BusErr;
    logic [1:0]       ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [2:0]       ImmSrc;
    logic [CNT_W-1:0] CycleCnt, InstRet;

    multicycle_ctrl #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero), .lt(lt), .ltu(ltu),
        .MemReady(MemReady), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .IllegalInstr(IllegalInstr),
        .BusErr(BusErr), .CycleCnt(CycleCnt), .InstRet(InstRet)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                           ITYPE = 7'b0010011, BRANCH = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    logic [6:0] legal_ops [9] = '{LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, JALR, LUI, AUIPC};

    int          errors = 0;
    int          checks = 0;
    int unsigned m_cycles = 0;
    int unsigned m_instret = 0;
    logic [2:0]  m_imm = 3'b000;
    logic [14:0] obs;

    assign obs = {AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, ALUSrcA, ALUSrcB, ALUOp,
                  ResultSrc, IllegalInstr, BusErr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] w(input logic adr, irw, pcu, rw, mw,
                                      input logic [1:0] a, b, alu, res, input logic ill, be);
        return {adr, irw, pcu, rw, mw, a, b, alu, res, ill, be};
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] imm_kind(input logic [6:0] o);
        if (o == STORE) return 3'b001;
        if (o == BRANCH) return 3'b010;
        if (o == JAL) return 3'b011;
        if (o == LUI || o == AUIPC) return 3'b100;
        return 3'b000;
    endfunction

    function automatic bit branch_taken(input logic [2:0] f, input logic [31:0] a, b);
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: entered and left just after a falling edge.
    task automatic step(input string tag, input logic mr, input logic [14:0] exp);
        MemReady = mr;
        #1;
        check(tag, 32'(obs), 32'(exp));
        check({tag, "_imm"}, 32'(ImmSrc), 32'(m_imm));
`ifdef MCYCLE_CNT_EN
        check({tag, "_cyc"}, CycleCnt, m_cycles);
        check({tag, "_ret"}, InstRet, m_instret);
`else
        check({tag, "_cyc"}, CycleCnt, 32'd0);
        check({tag, "_ret"}, InstRet, 32'd0);
`endif
        m_cycles++;
        @(negedge clk);
    endtask

    // Memory access with `stalls` not-ready cycles; the 4th not-ready cycle is a bus timeout.
    task automatic mem_phase(input string tag, input int stalls, input logic [14:0] wait_w,
                             input logic [14:0] done_w, input logic [14:0] err_w, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            if (i == 3) begin
                step({tag, "_buserr"}, 1'b0, err_w);
                aborted = 1'b1;
                return;
            end
            step({tag, "_wait"}, 1'b0, wait_w);
        end
        step(tag, 1'b1, done_w);
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic [31:0] ra, rb,
                             input int s_fetch, input int s_mem);
        bit ab;
        bit ill;
        bit bill;
        logic rnd;
        op = o;
        funct3 = f;
        Zero = (ra == rb);
        lt = $signed(ra) < $signed(rb);
        ltu = ra < rb;
        m_imm = imm_kind(o);
        rnd = 1'($urandom);
        mem_phase("fetch", s_fetch, w(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0),
                  w(0,1,1,0,0,2'b00,2'b10,2'b00,2'b10,0,0),
                  w(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,1), ab);
        if (ab) return;
        ill = !is_legal(o);
        step("decode", rnd, w(0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,ill,0));
        if (ill) return;
        case (o)
            LOAD: begin
                step("memadr", rnd, w(0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0));
                mem_phase("memread", s_mem, w(1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0),
                          w(1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0),
                          w(1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1), ab);
                if (ab) return;
                step("memwb", rnd, w(0,0,0,1,0,2'b00,2'b00,2'b00,2'b01,0,0));
                m_instret++;
            end
            STORE: begin
                step("memadr", rnd, w(0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0));
                mem_phase("memwrite", s_mem, w(1,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,0),
                          w(1,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,0),
                          w(1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1), ab);
                if (!ab) m_instret++;
            end
            BRANCH: begin
                bill = (f == 3'd2) || (f == 3'd3);
                step("branch", rnd, w(0,0,branch_taken(f, ra, rb),0,0,2'b10,2'b00,2'b01,2'b00,bill,0));
                if (!bill) m_instret++;
            end
            JAL, JALR: begin
                if (o == JAL) step("jal", rnd, w(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0));
                else          step("jalr", rnd, w(0,0,1,0,0,2'b10,2'b01,2'b00,2'b10,0,0));
                step("link", rnd, w(0,0,0,1,0,2'b01,2'b10,2'b00,2'b10,0,0));
                m_instret++;
            end
            default: begin
                if (o == RTYPE) step("execr", rnd, w(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0));
                if (o == ITYPE) step("execi", rnd, w(0,0,0,0,0,2'b10,2'b01,2'b10,2'b00,0,0));
                if (o == LUI)   step("lui", rnd, w(0,0,0,0,0,2'b11,2'b01,2'b00,2'b00,0,0));
                step("aluwb", rnd, w(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0));
                m_instret++;
            end
        endcase
    endtask

    initial begin
        logic [6:0]  o;
        logic [31:0] ra, rb;
        int          sf, sm;

        reset = 1'b1;
        MemReady = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_strobes", 32'({IRWrite, PCUpdate, RegWrite, MemWrite, IllegalInstr, BusErr}), 32'd0);
        check("reset_cyc", CycleCnt, 32'd0);
        reset = 1'b0;
        m_cycles = 0;
        m_instret = 0;

        run_instr(RTYPE, 3'd0, 32'd5, 32'd7, 0, 0);
        run_instr(LOAD, 3'd2, 32'd0, 32'd0, 0, 3);
        run_instr(BRANCH, 3'd1, 32'd1, 32'd2, 0, 0);
        run_instr(BRANCH, 3'd1, 32'd9, 32'd9, 0, 0);
        run_instr(BRANCH, 3'd2, 32'd1, 32'd2, 0, 0);
        run_instr(JALR, 3'd0, 32'd0, 32'd0, 0, 0);
        run_instr(RTYPE, 3'd0, 32'd0, 32'd0, 4, 0);
        run_instr(7'b0000000, 3'd0, 32'd0, 32'd0, 0, 0);
        run_instr(STORE, 3'd2, 32'd0, 32'd0, 1, 4);
        run_instr(AUIPC, 3'd0, 32'd0, 32'd0, 2, 0);

        // Reset lands while a store is still waiting for MemReady.
        op = STORE;
        m_imm = imm_kind(STORE);
        step("rst_fetch", 1'b1, w(0,1,1,0,0,2'b00,2'b10,2'b00,2'b10,0,0));
        step("rst_decode", 1'b1, w(0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0));
        step("rst_memadr", 1'b1, w(0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0));
        step("rst_memwrite", 1'b0, w(1,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,0));
        MemReady = 1'b0;
        #1;
        check("pre_rst_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_memwrite_off", 32'(MemWrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_cycles = 0;
        m_instret = 0;
        run_instr(ITYPE, 3'd0, 32'd0, 32'd0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) o = 7'($urandom);
            else o = legal_ops[$urandom_range(0, 8)];
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 3) == 0) rb = {~ra[31], rb[30:0]};
            sf = ($urandom_range(0, 19) == 0) ? 4 : $urandom_range(0, 3);
            sm = ($urandom_range(0, 19) == 0) ? 4 : $urandom_range(0, 3);
            run_instr(o, 3'($urandom), ra, rb, sf, sm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
